// File: rtl/tube_pkg.sv
// Shared types and helpers for the multi-channel tube timer.
package tube_pkg;

   typedef enum logic [1:0] {IDLE, RUN, READOUT} state_t;

   // Sliced down to CNT_W to form the "no hit" time value.
   localparam logic [31:0] TIME_NONE_32 = '1;

   function automatic int chan_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tube_sync_edge.sv
// Per-channel input synchroniser with rising-edge or level hit qualifier.
module tube_sync_edge #(
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = 1
) (
   input  logic clk,
   input  logic clr,
   input  logic pin_async,
   output logic hit_pulse
);

   logic [SYNC_STAGES-1:0] sync_pipe;
   logic                   last_q;

   always_ff @(posedge clk) begin
      if (clr) begin
         sync_pipe <= '0;
         last_q    <= 1'b0;
      end else begin
         sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], pin_async};
         last_q    <= sync_pipe[SYNC_STAGES-1];
      end
   end

   assign hit_pulse = (EDGE_MODE != 0) ? (sync_pipe[SYNC_STAGES-1] & ~last_q)
                                       : sync_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/tube_timer_array.sv
// Shared-window first-hit timer for N_TUBES channels with valid/ready record readout.
module tube_timer_array
   import tube_pkg::*;
#(
   parameter  int N_TUBES     = 8,
   parameter  int CNT_W       = 9,
   parameter  int WINDOW      = 511,
   parameter  int SYNC_STAGES = 2,
   parameter  int EDGE_MODE   = 1,
   localparam int CHAN_W      = chan_w(N_TUBES)
) (
   input  logic               clk,
   input  logic               clr,
   input  logic [N_TUBES-1:0] tube_pins,
   input  logic               arm,
   output logic               busy,
   output logic [N_TUBES-1:0] hit_mask,
   output logic               timeout,
   output logic               rd_valid,
   input  logic               rd_ready,
   output logic [CHAN_W-1:0]  rd_chan,
   output logic [CNT_W-1:0]   rd_time,
   output logic               rd_hit,
   output logic               rd_last
);

   localparam logic [CNT_W-1:0]  TIME_NONE = TIME_NONE_32[CNT_W-1:0];
   localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WINDOW - 1);
   localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(N_TUBES - 1);

   state_t                          state, state_nxt;
   logic [CNT_W-1:0]                counter;
   logic [N_TUBES-1:0][CNT_W-1:0]   time_q;
   logic [N_TUBES-1:0]              hit_pulse, new_hit, mask_nxt;
   logic [CHAN_W-1:0]               rd_idx;
   logic                            all_hit, expire, run_done, xfer;

   generate
      for (genvar g = 0; g < N_TUBES; g++) begin : g_ch
         tube_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE_MODE   (EDGE_MODE)
         ) u_sync (
            .clk       (clk),
            .clr       (clr),
            .pin_async (tube_pins[g]),
            .hit_pulse (hit_pulse[g])
         );
      end
   endgenerate

   // Completion looks at the mask including this cycle's captures.
   assign new_hit  = hit_pulse & ~hit_mask;
   assign mask_nxt = hit_mask | new_hit;
   assign all_hit  = &mask_nxt;
   assign expire   = (counter == LAST_CNT);
   assign run_done = all_hit | expire;
   assign xfer     = rd_valid & rd_ready;

   always_ff @(posedge clk) begin
      if (clr) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (arm)                            state_nxt = RUN;
         RUN:     if (run_done)                       state_nxt = READOUT;
         READOUT: if (xfer && (rd_idx == LAST_CHAN))  state_nxt = IDLE;
         default:                                     state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         counter  <= '0;
         hit_mask <= '0;
         timeout  <= 1'b0;
         time_q   <= {N_TUBES{TIME_NONE}};
         rd_idx   <= '0;
      end else begin
         case (state)
            IDLE: if (arm) begin
               counter  <= '0;
               hit_mask <= '0;
               timeout  <= 1'b0;
               time_q   <= {N_TUBES{TIME_NONE}};
               rd_idx   <= '0;
            end
            RUN: begin
               for (int i = 0; i < N_TUBES; i++)
                  if (new_hit[i]) time_q[i] <= counter;
               hit_mask <= mask_nxt;
               // Counter parks on the exit cycle so it never wraps.
               if (run_done) timeout <= expire & ~all_hit;
               else          counter <= counter + 1'b1;
            end
            READOUT: if (xfer)
               rd_idx <= (rd_idx == LAST_CHAN) ? '0 : rd_idx + 1'b1;
            default: ;
         endcase
      end
   end

   assign busy     = (state != IDLE);
   assign rd_valid = (state == READOUT);
   assign rd_chan  = rd_valid ? rd_idx : '0;
   assign rd_time  = rd_valid ? time_q[rd_idx] : '0;
   assign rd_hit   = rd_valid & hit_mask[rd_idx];
   assign rd_last  = rd_valid & (rd_idx == LAST_CHAN);

endmodule

// File: tb/tb_tube_timer_array.sv
// Randomised self-checking bench for tube_timer_array against a per-channel timing model.
module tb_tube_timer_array;

   localparam int N    = 8;
   localparam int W    = 9;
   localparam int WIN  = 511;
   localparam int NONE = 511;

   logic         clk = 1'b0;
   logic         clr, arm, rd_ready;
   logic [N-1:0] tube_pins;
   logic         busy, timeout, rd_valid, rd_hit, rd_last;
   logic [N-1:0] hit_mask;
   logic [2:0]   rd_chan;
   logic [W-1:0] rd_time;

   logic         arm2, rd_ready2;
   logic [1:0]   pins2, hit_mask2;
   logic         busy2, timeout2, rd_valid2, rd_hit2, rd_last2;
   logic [0:0]   rd_chan2;
   logic [4:0]   rd_time2;

   int total = 0;
   int bad   = 0;

   // rise[i]: -1 never, -2 high before arm, else counter value at whose closing edge the pin rises
   int           rise[N];
   int           exp_time[N];
   bit           exp_hit[N];
   logic [N-1:0] exp_mask;
   bit           exp_to;
   int           exp_x;
   int           ready_cycle;

   tube_timer_array dut (
      .clk(clk), .clr(clr), .tube_pins(tube_pins), .arm(arm), .busy(busy),
      .hit_mask(hit_mask), .timeout(timeout), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_chan(rd_chan), .rd_time(rd_time), .rd_hit(rd_hit), .rd_last(rd_last)
   );

   tube_timer_array #(
      .N_TUBES(2), .CNT_W(5), .WINDOW(16), .SYNC_STAGES(2), .EDGE_MODE(0)
   ) dut_lvl (
      .clk(clk), .clr(clr), .tube_pins(pins2), .arm(arm2), .busy(busy2),
      .hit_mask(hit_mask2), .timeout(timeout2), .rd_valid(rd_valid2), .rd_ready(rd_ready2),
      .rd_chan(rd_chan2), .rd_time(rd_time2), .rd_hit(rd_hit2), .rd_last(rd_last2)
   );

   always #5 clk = ~clk;

   // A channel is seen two cycles after its pin rises; window ends at the
   // last hit if everyone hits in time, otherwise at counter WIN-1.
   task automatic compute_model();
      bit all = 1;
      int mx  = 0;
      for (int i = 0; i < N; i++) begin
         if (rise[i] < 0) all = 0;
         else if (rise[i] + 2 > mx) mx = rise[i] + 2;
      end
      exp_x = (all && mx <= WIN - 1) ? mx : WIN - 1;
      for (int i = 0; i < N; i++) begin
         exp_hit[i]  = (rise[i] >= 0) && (rise[i] + 2 <= exp_x);
         exp_time[i] = exp_hit[i] ? rise[i] + 2 : NONE;
         exp_mask[i] = exp_hit[i];
      end
      exp_to = (exp_mask != {N{1'b1}});
   endtask

   task automatic clear_rise();
      for (int i = 0; i < N; i++) rise[i] = -1;
   endtask

   task automatic run_window(input int arm_at, input int clr_at);
      ready_cycle = -1;
      compute_model();
      rd_ready = 1'b0;
      for (int i = 0; i < N; i++) tube_pins[i] = (rise[i] == -2);
      repeat (4) @(negedge clk);
      arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
      for (int c = 0; c <= WIN + 4; c++) begin
         if (rd_valid) begin ready_cycle = c; break; end
         total++;
         if (busy !== 1'b1) begin
            bad++; $display("FAIL busy_run: got %b expected 1 at count %0d", busy, c);
         end
         for (int i = 0; i < N; i++)
            tube_pins[i] = (rise[i] == -2) || (rise[i] >= 0 && c >= rise[i]);
         arm = (c == arm_at);
         clr = (c == clr_at);
         @(negedge clk);
         arm = 1'b0;
         if (clr) begin
            clr = 1'b0;
            total++;
            if (busy !== 1'b0 || rd_valid !== 1'b0 || hit_mask !== '0 || timeout !== 1'b0) begin
               bad++;
               $display("FAIL abort_state: got busy=%b valid=%b mask=%h to=%b expected 0/0/00/0",
                        busy, rd_valid, hit_mask, timeout);
            end
            return;
         end
      end
      total++;
      if (ready_cycle != exp_x + 1) begin
         bad++; $display("FAIL readout_start: got cycle %0d expected %0d", ready_cycle, exp_x + 1);
      end
   endtask

   // mode 0: always ready; 1: random ready; 2: stall 20 cycles then toggle 1/0
   task automatic read_all(input int mode);
      int k = 0;
      int n = 0;
      int lasts = 0;
      while (k < N) begin
         if (n > 400) begin
            bad++; total++; $display("FAIL readout_budget: got %0d records expected %0d", k, N);
            break;
         end
         total++;
         if (rd_valid !== 1'b1) begin
            bad++; $display("FAIL rd_valid: got %b expected 1 at record %0d", rd_valid, k);
            break;
         end
         total++;
         if (rd_chan !== 3'(k)) begin
            bad++; $display("FAIL rd_chan: got %0d expected %0d", rd_chan, k);
         end
         total++;
         if (rd_time !== W'(exp_time[k])) begin
            bad++; $display("FAIL rd_time ch%0d: got %0d expected %0d", k, rd_time, exp_time[k]);
         end
         total++;
         if (rd_hit !== exp_hit[k]) begin
            bad++; $display("FAIL rd_hit ch%0d: got %b expected %b", k, rd_hit, exp_hit[k]);
         end
         total++;
         if (rd_last !== (k == N - 1)) begin
            bad++; $display("FAIL rd_last ch%0d: got %b expected %b", k, rd_last, k == N - 1);
         end
         total++;
         if (busy !== 1'b1) begin
            bad++; $display("FAIL busy_readout: got %b expected 1", busy);
         end
         case (mode)
            0:       rd_ready = 1'b1;
            1:       rd_ready = 1'($urandom_range(0, 1));
            default: rd_ready = (n >= 20) && ((n - 20) % 2 == 0);
         endcase
         tube_pins = N'($urandom);
         @(negedge clk);
         n++;
         if (rd_ready) begin
            if (rd_last === 1'b0 && k == N - 1) ; else if (k == N - 1) lasts++;
            k++;
         end
      end
      rd_ready  = 1'b0;
      tube_pins = '0;
      total++;
      if (rd_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL readout_end: got valid=%b busy=%b expected 0/0", rd_valid, busy);
      end
      total++;
      if (hit_mask !== exp_mask) begin
         bad++; $display("FAIL hit_mask: got %h expected %h", hit_mask, exp_mask);
      end
      total++;
      if (timeout !== exp_to) begin
         bad++; $display("FAIL timeout: got %b expected %b", timeout, exp_to);
      end
   endtask

   task automatic test_reset();
      tube_pins = N'($urandom); pins2 = 2'($urandom);
      arm = 1'b0; arm2 = 1'b0; rd_ready = 1'b0; rd_ready2 = 1'b0;
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      total++;
      if ({busy, rd_valid, timeout, rd_hit, rd_last} !== 5'b0 || hit_mask !== '0 ||
          rd_chan !== '0 || rd_time !== '0) begin
         bad++;
         $display("FAIL reset_state: got busy=%b valid=%b to=%b hit=%b last=%b mask=%h chan=%0d time=%0d expected all 0",
                  busy, rd_valid, timeout, rd_hit, rd_last, hit_mask, rd_chan, rd_time);
      end
      total++;
      if ({busy2, rd_valid2, timeout2} !== 3'b0 || hit_mask2 !== '0) begin
         bad++; $display("FAIL reset_lvl: got busy=%b valid=%b to=%b mask=%b expected 0", busy2, rd_valid2, timeout2, hit_mask2);
      end
      tube_pins = '0; pins2 = '0;
   endtask

   task automatic test_single_hit();
      clear_rise(); rise[3] = 10;
      run_window(-1, -1); read_all(0);
   endtask

   task automatic test_early_completion();
      for (int i = 0; i < N; i++) rise[i] = 5;
      run_window(-1, -1); read_all(0);
   endtask

   task automatic test_window_boundary();
      for (int i = 0; i < N; i++) rise[i] = $urandom_range(0, 100);
      rise[6] = WIN - 3;
      run_window(-1, -1); read_all(1);
      rise[6] = WIN - 2;
      run_window(-1, -1); read_all(1);
   endtask

   task automatic test_back_to_back();
      clear_rise(); rise[0] = 2; rise[7] = 0;
      for (int i = 1; i < 7; i++) rise[i] = 4 + i;
      run_window(-1, -1); read_all(2);
   endtask

   task automatic test_edge_prehigh();
      clear_rise(); rise[0] = -2; rise[5] = 40;
      run_window(-1, -1); read_all(0);
   endtask

   task automatic test_level_mode();
      int c;
      pins2 = 2'b01; rd_ready2 = 1'b0;
      repeat (4) @(negedge clk);
      arm2 = 1'b1;
      @(negedge clk);
      arm2 = 1'b0;
      for (c = 0; c < 40; c++) begin
         if (rd_valid2) break;
         @(negedge clk);
      end
      total++;
      if (c != 16) begin bad++; $display("FAIL lvl_start: got cycle %0d expected 16", c); end
      rd_ready2 = 1'b1;
      total++;
      if ({rd_valid2, rd_chan2, rd_time2, rd_hit2, rd_last2} !== {1'b1, 1'b0, 5'd0, 1'b1, 1'b0}) begin
         bad++; $display("FAIL lvl_rec0: got v=%b ch=%0d t=%0d h=%b l=%b expected 1/0/0/1/0",
                         rd_valid2, rd_chan2, rd_time2, rd_hit2, rd_last2);
      end
      @(negedge clk);
      total++;
      if ({rd_valid2, rd_chan2, rd_time2, rd_hit2, rd_last2} !== {1'b1, 1'b1, 5'd31, 1'b0, 1'b1}) begin
         bad++; $display("FAIL lvl_rec1: got v=%b ch=%0d t=%0d h=%b l=%b expected 1/1/31/0/1",
                         rd_valid2, rd_chan2, rd_time2, rd_hit2, rd_last2);
      end
      @(negedge clk);
      rd_ready2 = 1'b0; pins2 = '0;
      total++;
      if ({rd_valid2, busy2, timeout2, hit_mask2} !== {1'b0, 1'b0, 1'b1, 2'b01}) begin
         bad++; $display("FAIL lvl_end: got v=%b busy=%b to=%b mask=%b expected 0/0/1/01",
                         rd_valid2, busy2, timeout2, hit_mask2);
      end
   endtask

   task automatic test_abort_and_ignore();
      clear_rise(); rise[1] = 30; rise[2] = 60;
      run_window(50, -1); read_all(0);
      run_window(-1, 100);
      clear_rise(); rise[3] = 3;
      run_window(-1, -1); read_all(1);
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         for (int i = 0; i < N; i++)
            rise[i] = (it % 2 == 0 || $urandom_range(0, 3) != 0) ? int'($urandom_range(0, 60)) : -1;
         run_window(-1, -1); read_all(1);
      end
   endtask

   initial begin
      test_reset();
      test_single_hit();
      test_early_completion();
      test_window_boundary();
      test_back_to_back();
      test_edge_prehigh();
      test_level_mode();
      test_abort_and_ignore();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tube_timer_array.md
Name: tube_timer_array

Overview:
Multi-channel successor to the single-tube cycle counter. One shared window counter times the first hit on each of N_TUBES tube inputs after an arm pulse. Each channel's input is synchronised and qualified by edge or level. When every tube has hit, or the window expires, the block streams one record per channel over a valid/ready readout port to the downstream packer/readout logic.

Parameters:
N_TUBES, 8, number of tube channels (>=1)
CNT_W, 9, width of the window counter and time fields
WINDOW, 511, window length in cycles; legal range 1..2^CNT_W-1
SYNC_STAGES, 2, flip-flop synchroniser depth per channel (>=2)
EDGE_MODE, 1, 1 = hit on synchronised rising edge; 0 = hit on synchronised high level

Ports:
clk  in  1  system clock
clr  in  1  synchronous active-high reset/clear
tube_pins  in  N_TUBES  raw asynchronous tube discriminator inputs
arm  in  1  start-of-window request; sampled only in IDLE
busy  out  1  high in RUN and READOUT
hit_mask  out  N_TUBES  per-channel hit flags for the current/last window
timeout  out  1  last window ended by expiry with at least one channel unhit
rd_valid  out  1  readout record valid
rd_ready  in  1  downstream accepts record
rd_chan  out  CHAN_W  channel index of record; CHAN_W = max(1, clog2(N_TUBES))
rd_time  out  CNT_W  captured hit time, or all-ones if not hit
rd_hit  out  1  channel hit within window
rd_last  out  1  record is channel N_TUBES-1

Behaviour:
- One clock (clk). Reset is synchronous and active-high (clr). The polarity and synchronicity are fixed.
- Reset state, applied at the clk edge with clr=1, overriding all else in any state:
  - state=IDLE; counter=0; hit_mask=0; timeout=0; busy=0.
  - rd_valid=0; rd_chan=0; rd_time=0; rd_hit=0; rd_last=0.
  - All time registers = all-ones; synchroniser and edge history = 0.
- Synchronisers run in every state.
- Edge mode: a hit is the cycle in which the last sync stage is 1 and its registered previous value is 0.
- Level mode: a hit is any cycle in which the last sync stage is 1.
- IDLE:
  - arm=1 -> RUN next cycle.
  - On the same edge: counter=0, hit_mask=0, timeout=0, time registers=all-ones.
- RUN:
  - Counter increments by 1 per cycle, starting from 0 in the first RUN cycle.
  - For channel i with a qualified hit and hit_mask[i]=0: time[i] <= counter and hit_mask[i] <= 1.
  - Later hits on an already-hit channel are ignored (first hit only).
  - Hit latency: if the raw pin is first sampled high at the closing edge of the cycle with counter=c, then rd_time=c+SYNC_STAGES.
  - Edge mode: a pin already high at arm is not a hit.
  - Exit to READOUT at the end of a cycle where:
    - (a) all channels are hit after that cycle's captures, or
    - (b) counter==WINDOW-1.
  - Hits detected in the exit cycle are captured.
  - timeout <= 1 only on (b) with hit_mask not all ones. If (a) and (b) coincide, timeout=0.
  - Counter never wraps.
- READOUT:
  - rd_valid=1 starting the first READOUT cycle, with channel 0.
  - Record fields: rd_chan=k, rd_time=time[k], rd_hit=hit_mask[k], rd_last=(k==N_TUBES-1).
  - Transfer happens on rd_valid & rd_ready; k then advances the next cycle.
  - While rd_valid & !rd_ready, all rd_* fields hold stable.
  - After the rd_last transfer: rd_valid=0 and state=IDLE on the next cycle.
  - hit_mask and timeout hold until the next accepted arm or clr.
- arm is ignored in RUN and READOUT.
- tube_pins activity during READOUT/IDLE does not change captured data.
- clr mid-RUN or mid-READOUT aborts immediately; the partial record stream is discarded.
- rd_valid=1 with rd_ready held 0 is a legal indefinite stall; busy stays 1.

Decomposition:
- Package tube_pkg holds:
  - state enum {IDLE, RUN, READOUT};
  - CHAN_W computation function;
  - all-ones time sentinel constant.
- Sub-module tube_sync_edge: per-channel SYNC_STAGES synchroniser plus edge/level qualifier.
  - Ports: clk, clr, pin_async, hit_pulse.
  - Instantiated N_TUBES times via generate.
- FSM, counter, capture registers and readout mux live in the top.

Test Plan:
- Reset: drive clr for 1 cycle with random pins -> all outputs at reset values; busy=0, rd_valid=0.
- Single hit timing (defaults): arm; raise tube_pins[3] just before the edge where counter=10; all other pins low -> after expiry, 8 records; ch3 rd_time=12, rd_hit=1; other channels rd_time=511, rd_hit=0; timeout=1.
- Early completion: arm; raise all 8 pins at counter=5 -> READOUT entered after counter=7 cycle; every rd_time=7; timeout=0; busy falls after last transfer.
- Backpressure: hold rd_ready=0 for 20 cycles, then toggle 1/0 every cycle -> fields stable while stalled; records 0..7 in order; exactly one rd_last=1.
- Edge mode pre-high: pin 0 held high before arm -> ch0 rd_hit=0. Repeat with EDGE_MODE=0 -> ch0 rd_time=0, rd_hit=1.
- Abort and ignore: arm pulse during RUN -> counter unaffected. clr at counter=100 -> IDLE next cycle, hit_mask=0. Subsequent arm -> fresh window from 0.
